// File: rtl/fc_param_scheduler.sv
// fc_param_scheduler: streams weight and bias tiles from ROMs to a linear layer.
// Each ROM read lands in a 2-entry FIFO; reads are credit-limited by occupancy.
module fc_param_scheduler #(
   parameter  int WEIGHT_PRECISION_0       = 8,
   parameter  int WEIGHT_TENSOR_SIZE_DIM_0 = 20,
   parameter  int WEIGHT_PARALLELISM_DIM_0 = 4,
   parameter  int WEIGHT_TENSOR_SIZE_DIM_1 = 10,
   parameter  int WEIGHT_PARALLELISM_DIM_1 = 10,
   parameter  int BIAS_PRECISION_0         = 8,
   parameter  int FRAME_WIDTH              = 16,
   localparam int IN_DEPTH  = WEIGHT_TENSOR_SIZE_DIM_0 / WEIGHT_PARALLELISM_DIM_0,
   localparam int OUT_DEPTH = WEIGHT_TENSOR_SIZE_DIM_1 / WEIGHT_PARALLELISM_DIM_1,
   localparam int W_AW = (IN_DEPTH * OUT_DEPTH > 1) ? $clog2(IN_DEPTH * OUT_DEPTH) : 1,
   localparam int B_AW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1,
   localparam int W_N  = WEIGHT_PARALLELISM_DIM_0 * WEIGHT_PARALLELISM_DIM_1,
   localparam int B_N  = WEIGHT_PARALLELISM_DIM_1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [FRAME_WIDTH-1:0]        num_frames,
   input  logic                          abort,
   output logic                          busy,
   output logic                          done,
   output logic                          w_rom_en,
   output logic [W_AW-1:0]               w_rom_addr,
   input  logic [WEIGHT_PRECISION_0-1:0] w_rom_data [W_N],
   output logic                          b_rom_en,
   output logic [B_AW-1:0]               b_rom_addr,
   input  logic [BIAS_PRECISION_0-1:0]   b_rom_data [B_N],
   output logic [WEIGHT_PRECISION_0-1:0] weight [W_N],
   output logic                          weight_valid,
   input  logic                          weight_ready,
   output logic [BIAS_PRECISION_0-1:0]   bias [B_N],
   output logic                          bias_valid,
   input  logic                          bias_ready
);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

   localparam logic [W_AW-1:0] I_LAST = W_AW'(IN_DEPTH - 1);
   localparam logic [B_AW-1:0] J_LAST = B_AW'(OUT_DEPTH - 1);

   state_t state, state_nx;

   logic [W_AW-1:0]        i_cnt;
   logic [W_AW-1:0]        w_addr;
   logic [B_AW-1:0]        j_cnt;
   logic [FRAME_WIDTH-1:0] frame;
   logic [FRAME_WIDTH-1:0] frames;

   logic       w_fly, b_fly;
   logic [1:0] w_cnt, b_cnt;
   logic       w_wp, w_rp, b_wp, b_rp;
   logic [2:0] w_occ, b_occ;
   logic       w_pop, b_pop;
   logic       w_room, b_room;
   logic       need_b, rd, last_rd;
   logic       i_wrap, j_wrap;
   logic       accept, kill, drained;

   logic [WEIGHT_PRECISION_0-1:0] w_mem [2][W_N];
   logic [BIAS_PRECISION_0-1:0]   b_mem [2][B_N];

   assign weight_valid = (w_cnt != 2'd0);
   assign bias_valid   = (b_cnt != 2'd0);
   assign w_pop        = weight_valid & weight_ready;
   assign b_pop        = bias_valid & bias_ready;

   // occupancy after this cycle's pop, counting the read still in flight
   assign w_occ  = 3'(w_cnt) + 3'(w_fly) - 3'(w_pop);
   assign b_occ  = 3'(b_cnt) + 3'(b_fly) - 3'(b_pop);
   assign w_room = (w_occ < 3'd2);
   assign b_room = (b_occ < 3'd2);

   assign need_b  = (i_cnt == '0);
   assign rd      = (state == RUN) && !abort && w_room && (!need_b || b_room);
   assign i_wrap  = (i_cnt == I_LAST);
   assign j_wrap  = (j_cnt == J_LAST);
   assign last_rd = rd && i_wrap && j_wrap
                 && (frame == frames - FRAME_WIDTH'(1));

   assign accept  = (state == IDLE) && start && !abort && (num_frames != '0);
   assign kill    = abort && ((state == RUN) || (state == FLUSH));
   assign drained = (w_occ == 3'd0) && (b_occ == 3'd0);

   assign w_rom_en   = rd;
   assign w_rom_addr = w_addr;
   assign b_rom_en   = rd && need_b;
   assign b_rom_addr = j_cnt;

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   // next-state and status outputs
   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      unique case (state)
         IDLE: begin
            if (start && !abort)
               state_nx = (num_frames == '0) ? DONE : RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (abort)        state_nx = IDLE;
            else if (last_rd) state_nx = FLUSH;
         end
         FLUSH: begin
            busy = 1'b1;
            if (abort)        state_nx = IDLE;
            else if (drained) state_nx = DONE;
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
      endcase
   end

   // tile walk: i inner, j outer, then frame
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         i_cnt  <= '0;
         j_cnt  <= '0;
         w_addr <= '0;
         frame  <= '0;
         frames <= '0;
      end else if (accept) begin
         i_cnt  <= '0;
         j_cnt  <= '0;
         w_addr <= '0;
         frame  <= '0;
         frames <= num_frames;
      end else if (rd) begin
         if (!i_wrap) begin
            i_cnt  <= i_cnt + W_AW'(1);
            w_addr <= w_addr + W_AW'(1);
         end else begin
            i_cnt <= '0;
            if (j_wrap) begin
               j_cnt  <= '0;
               w_addr <= '0;
               frame  <= frame + FRAME_WIDTH'(1);
            end else begin
               j_cnt  <= j_cnt + B_AW'(1);
               w_addr <= w_addr + W_AW'(1);
            end
         end
      end
   end

   // one-cycle ROM latency tracking; abort discards what is in flight
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         w_fly <= 1'b0;
         b_fly <= 1'b0;
      end else begin
         w_fly <= rd && !kill;
         b_fly <= b_rom_en && !kill;
      end
   end

   // FIFO pointers and counts
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         w_cnt <= '0;
         w_wp  <= 1'b0;
         w_rp  <= 1'b0;
         b_cnt <= '0;
         b_wp  <= 1'b0;
         b_rp  <= 1'b0;
      end else if (kill) begin
         w_cnt <= '0;
         w_wp  <= 1'b0;
         w_rp  <= 1'b0;
         b_cnt <= '0;
         b_wp  <= 1'b0;
         b_rp  <= 1'b0;
      end else begin
         w_cnt <= w_cnt + 2'(w_fly) - 2'(w_pop);
         b_cnt <= b_cnt + 2'(b_fly) - 2'(b_pop);
         if (w_fly) w_wp <= ~w_wp;
         if (w_pop) w_rp <= ~w_rp;
         if (b_fly) b_wp <= ~b_wp;
         if (b_pop) b_rp <= ~b_rp;
      end
   end

   // FIFO storage captures ROM data the cycle after the read
   always_ff @(posedge clk) begin
      if (w_fly)
         for (int k = 0; k < W_N; k++) w_mem[w_wp][k] <= w_rom_data[k];
      if (b_fly)
         for (int k = 0; k < B_N; k++) b_mem[b_wp][k] <= b_rom_data[k];
   end

   // head entries drive the streams and stay put while stalled
   always_comb begin
      for (int k = 0; k < W_N; k++) weight[k] = w_mem[w_rp][k];
      for (int k = 0; k < B_N; k++) bias[k] = b_mem[b_rp][k];
   end

endmodule

// File: tb/tb_fc_param_scheduler.sv
// tb_fc_param_scheduler: directed scenarios for fc_param_scheduler.
// ROM models tag each tile with its address so order can be checked.
module tb_fc_param_scheduler;

   localparam int FW   = 16;
   localparam int W_N  = 40;
   localparam int B_N  = 10;
   localparam int W_AW = 3;
   localparam int B_AW = 1;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [FW-1:0]   num_frames;
   logic            abort;
   logic            busy, done;
   logic            w_rom_en, b_rom_en;
   logic [W_AW-1:0] w_rom_addr;
   logic [B_AW-1:0] b_rom_addr;
   logic [7:0]      w_rom_data [W_N];
   logic [7:0]      b_rom_data [B_N];
   logic [7:0]      weight [W_N];
   logic [7:0]      bias [B_N];
   logic            weight_valid, weight_ready;
   logic            bias_valid, bias_ready;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   int wa_q[$], wa_c[$], ba_q[$], ba_c[$];
   int wx_q[$], wl_q[$], wx_c[$], bx_q[$], dn_c[$];

   always #5 clk = ~clk;

   fc_param_scheduler dut (
      .clk(clk), .rst(rst), .start(start), .num_frames(num_frames),
      .abort(abort), .busy(busy), .done(done),
      .w_rom_en(w_rom_en), .w_rom_addr(w_rom_addr), .w_rom_data(w_rom_data),
      .b_rom_en(b_rom_en), .b_rom_addr(b_rom_addr), .b_rom_data(b_rom_data),
      .weight(weight), .weight_valid(weight_valid), .weight_ready(weight_ready),
      .bias(bias), .bias_valid(bias_valid), .bias_ready(bias_ready)
   );

   // ROM models with one-cycle read latency
   always @(posedge clk) begin
      if (w_rom_en)
         for (int k = 0; k < W_N; k++)
            w_rom_data[k] <= 8'(int'(w_rom_addr) * 41 + k);
      if (b_rom_en)
         for (int k = 0; k < B_N; k++)
            b_rom_data[k] <= 8'(160 + int'(b_rom_addr) * 16 + k);
   end

   // activity log sampled mid-cycle
   always @(negedge clk) begin
      if (w_rom_en) begin
         wa_q.push_back(int'(w_rom_addr));
         wa_c.push_back(cyc);
      end
      if (b_rom_en) begin
         ba_q.push_back(int'(b_rom_addr));
         ba_c.push_back(cyc);
      end
      if (weight_valid && weight_ready) begin
         wx_q.push_back(int'(weight[0]));
         wl_q.push_back(int'(weight[W_N-1]));
         wx_c.push_back(cyc);
      end
      if (bias_valid && bias_ready) bx_q.push_back(int'(bias[0]));
      if (done) dn_c.push_back(cyc);
      cyc++;
   end

   task automatic clear_logs();
      wa_q.delete(); wa_c.delete(); ba_q.delete(); ba_c.delete();
      wx_q.delete(); wl_q.delete(); wx_c.delete(); bx_q.delete();
      dn_c.delete();
   endtask

   task automatic start_job(input int nf);
      @(posedge clk); #1;
      start = 1'b1;
      num_frames = FW'(nf);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int lim, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < lim && !ok; n++) begin
         @(negedge clk); #1;
         if (dn_c.size() > 0) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; start = 1'b0; abort = 1'b0; num_frames = '0;
      weight_ready = 1'b0; bias_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({busy, done, weight_valid, bias_valid, w_rom_en, b_rom_en} !== 6'b0) begin
         bad++;
         $display("FAIL reset_ctrl got=%b want=000000",
                  {busy, done, weight_valid, bias_valid, w_rom_en, b_rom_en});
      end
      total++;
      if ({w_rom_addr, b_rom_addr} !== 4'b0) begin
         bad++;
         $display("FAIL reset_addr got=%b want=0000", {w_rom_addr, b_rom_addr});
      end
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      total++;
      if (busy !== 1'b0 || w_rom_en !== 1'b0) begin
         bad++;
         $display("FAIL reset_idle busy=%b en=%b want 0 0", busy, w_rom_en);
      end
   endtask

   task automatic test_basic();
      bit ok;
      clear_logs();
      weight_ready = 1'b1; bias_ready = 1'b1;
      start_job(2);
      wait_done(100, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL basic_done got=timeout want=done"); end
      repeat (4) @(negedge clk);
      #1;
      total++;
      if (wa_q.size() !== 10) begin
         bad++; $display("FAIL basic_nreads got=%0d want=10", wa_q.size());
      end
      for (int k = 0; k < wa_q.size(); k++) begin
         total++;
         if (wa_q[k] !== k % 5) begin
            bad++; $display("FAIL basic_addr[%0d] got=%0d want=%0d", k, wa_q[k], k % 5);
         end
      end
      for (int k = 1; k < wa_c.size(); k++) begin
         total++;
         if (wa_c[k] !== wa_c[k-1] + 1) begin
            bad++; $display("FAIL basic_gap[%0d] got=%0d want=1", k, wa_c[k] - wa_c[k-1]);
         end
      end
      total++;
      if (ba_q.size() !== 2) begin
         bad++; $display("FAIL basic_nbias got=%0d want=2", ba_q.size());
      end else begin
         total++;
         if (ba_q[0] !== 0 || ba_q[1] !== 0) begin
            bad++; $display("FAIL basic_baddr got=%0d,%0d want=0,0", ba_q[0], ba_q[1]);
         end
         if (wa_c.size() == 10) begin
            total++;
            if (ba_c[0] !== wa_c[0] || ba_c[1] !== wa_c[5]) begin
               bad++;
               $display("FAIL basic_bcyc got=%0d,%0d want=%0d,%0d",
                        ba_c[0], ba_c[1], wa_c[0], wa_c[5]);
            end
         end
      end
      total++;
      if (wx_q.size() !== 10) begin
         bad++; $display("FAIL basic_nxfer got=%0d want=10", wx_q.size());
      end
      for (int k = 0; k < wx_q.size(); k++) begin
         total++;
         if (wx_q[k] !== (k % 5) * 41 || wl_q[k] !== (k % 5) * 41 + 39) begin
            bad++;
            $display("FAIL basic_tile[%0d] got=%0d/%0d want=%0d/%0d", k,
                     wx_q[k], wl_q[k], (k % 5) * 41, (k % 5) * 41 + 39);
         end
      end
      total++;
      if (bx_q.size() !== 2 || (bx_q.size() == 2 && bx_q[1] !== 160)) begin
         bad++; $display("FAIL basic_bias got=%0d tiles want=2 of 160", bx_q.size());
      end
      total++;
      if (dn_c.size() !== 1) begin
         bad++; $display("FAIL basic_npulse got=%0d want=1", dn_c.size());
      end else if (wx_c.size() == 10) begin
         total++;
         if (dn_c[0] !== wx_c[9] + 1) begin
            bad++;
            $display("FAIL basic_done_lat got=%0d want=1", dn_c[0] - wx_c[9]);
         end
      end
   endtask

   task automatic test_stall();
      bit seen, stl;
      int pv, pl, nst;
      clear_logs();
      weight_ready = 1'b1; bias_ready = 1'b1;
      start_job(2);
      seen = 1'b0; stl = 1'b0; pv = 0; pl = 0; nst = 0;
      for (int n = 0; n < 200 && !seen; n++) begin
         @(negedge clk); #1;
         if (stl) begin
            nst++;
            total++;
            if (weight_valid !== 1'b1 || int'(weight[0]) !== pv
                || int'(weight[W_N-1]) !== pl) begin
               bad++;
               $display("FAIL stall_hold got=%b/%0d want=1/%0d",
                        weight_valid, weight[0], pv);
            end
         end
         stl = weight_valid && !weight_ready;
         pv  = int'(weight[0]);
         pl  = int'(weight[W_N-1]);
         if (done) seen = 1'b1;
         @(posedge clk); #1;
         weight_ready = ~weight_ready;
      end
      weight_ready = 1'b1;
      total++;
      if (!seen) begin bad++; $display("FAIL stall_done got=timeout want=done"); end
      total++;
      if (nst == 0) begin bad++; $display("FAIL stall_seen got=0 want>0"); end
      total++;
      if (wx_q.size() !== 10) begin
         bad++; $display("FAIL stall_nxfer got=%0d want=10", wx_q.size());
      end
      for (int k = 0; k < wx_q.size(); k++) begin
         total++;
         if (wx_q[k] !== (k % 5) * 41) begin
            bad++; $display("FAIL stall_tile[%0d] got=%0d want=%0d", k, wx_q[k], (k % 5) * 41);
         end
      end
   endtask

   task automatic test_bias_block();
      bit ok;
      clear_logs();
      weight_ready = 1'b1; bias_ready = 1'b0;
      start_job(4);
      repeat (20) @(negedge clk);
      #1;
      total++;
      if (wa_q.size() !== 10 || ba_q.size() !== 2) begin
         bad++;
         $display("FAIL bblk_reads got=%0d/%0d want=10/2", wa_q.size(), ba_q.size());
      end
      total++;
      if (busy !== 1'b1 || w_rom_en !== 1'b0 || bias_valid !== 1'b1
          || dn_c.size() !== 0) begin
         bad++;
         $display("FAIL bblk_hold got=%b%b%b want=101", busy, w_rom_en, bias_valid);
      end
      @(posedge clk); #1;
      bias_ready = 1'b1;
      wait_done(200, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL bblk_done got=timeout want=done"); end
      total++;
      if (wx_q.size() !== 20 || bx_q.size() !== 4 || wa_q.size() !== 20) begin
         bad++;
         $display("FAIL bblk_count got=%0d/%0d/%0d want=20/4/20",
                  wx_q.size(), bx_q.size(), wa_q.size());
      end
      for (int k = 0; k < wx_q.size(); k++) begin
         total++;
         if (wx_q[k] !== (k % 5) * 41) begin
            bad++; $display("FAIL bblk_tile[%0d] got=%0d want=%0d", k, wx_q[k], (k % 5) * 41);
         end
      end
   endtask

   task automatic test_zero();
      int dk;
      clear_logs();
      dk = -1;
      @(posedge clk); #1;
      start = 1'b1;
      num_frames = '0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk); #1;
         total++;
         if (busy !== 1'b0) begin
            bad++; $display("FAIL zero_busy[%0d] got=%b want=0", k, busy);
         end
         if (done && dk < 0) dk = k;
         @(posedge clk); #1;
         start = 1'b0;
      end
      total++;
      if (dn_c.size() !== 1) begin
         bad++; $display("FAIL zero_npulse got=%0d want=1", dn_c.size());
      end
      total++;
      if (dk < 1 || dk > 2) begin
         bad++; $display("FAIL zero_lat got=%0d want=1..2", dk);
      end
      total++;
      if (wa_q.size() !== 0 || ba_q.size() !== 0) begin
         bad++; $display("FAIL zero_reads got=%0d/%0d want=0/0", wa_q.size(), ba_q.size());
      end
   endtask

   task automatic test_abort();
      bit ok;
      int nb;
      clear_logs();
      weight_ready = 1'b1; bias_ready = 1'b1;
      start_job(3);
      ok = 1'b0;
      for (int n = 0; n < 50 && !ok; n++) begin
         @(negedge clk); #1;
         if (wx_q.size() >= 3) ok = 1'b1;
      end
      total++;
      if (!ok) begin bad++; $display("FAIL abort_wait got=timeout want=3 xfers"); end
      @(posedge clk); #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk); #1;
      total++;
      if ({weight_valid, bias_valid, busy, w_rom_en} !== 4'b0) begin
         bad++;
         $display("FAIL abort_drop got=%b want=0000",
                  {weight_valid, bias_valid, busy, w_rom_en});
      end
      nb = wx_q.size();
      repeat (6) @(negedge clk);
      #1;
      total++;
      if (dn_c.size() !== 0 || wx_q.size() !== nb) begin
         bad++;
         $display("FAIL abort_quiet got=%0d done/%0d xfer want=0/%0d",
                  dn_c.size(), wx_q.size(), nb);
      end
      clear_logs();
      @(posedge clk); #1;
      start = 1'b1; abort = 1'b1; num_frames = FW'(2);
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      total++;
      if (busy !== 1'b0 || wa_q.size() !== 0 || dn_c.size() !== 0) begin
         bad++;
         $display("FAIL abort_prio got=%b/%0d/%0d want=0/0/0",
                  busy, wa_q.size(), dn_c.size());
      end
      clear_logs();
      start_job(1);
      wait_done(100, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL abort_restart got=timeout want=done"); end
      total++;
      if (wa_q.size() !== 5 || wx_q.size() !== 5) begin
         bad++;
         $display("FAIL abort_rcount got=%0d/%0d want=5/5", wa_q.size(), wx_q.size());
      end
      for (int k = 0; k < wx_q.size(); k++) begin
         total++;
         if (wx_q[k] !== k * 41 || wa_q[k] !== k) begin
            bad++;
            $display("FAIL abort_rtile[%0d] got=%0d@%0d want=%0d@%0d",
                     k, wx_q[k], wa_q[k], k * 41, k);
         end
      end
   endtask

   task automatic test_reset_flush();
      clear_logs();
      weight_ready = 1'b1; bias_ready = 1'b0;
      start_job(1);
      repeat (12) @(negedge clk);
      #1;
      total++;
      if (busy !== 1'b1 || w_rom_en !== 1'b0 || bias_valid !== 1'b1
          || wa_q.size() !== 5) begin
         bad++;
         $display("FAIL rflush_state got=%b%b%b/%0d want=101/5",
                  busy, w_rom_en, bias_valid, wa_q.size());
      end
      #2;
      rst = 1'b0;
      #1;
      total++;
      if ({busy, done, weight_valid, bias_valid, w_rom_en, b_rom_en} !== 6'b0) begin
         bad++;
         $display("FAIL rflush_async got=%b want=000000",
                  {busy, done, weight_valid, bias_valid, w_rom_en, b_rom_en});
      end
      total++;
      if ({w_rom_addr, b_rom_addr} !== 4'b0) begin
         bad++; $display("FAIL rflush_addr got=%b want=0000", {w_rom_addr, b_rom_addr});
      end
      @(posedge clk); #1;
      rst = 1'b1;
      bias_ready = 1'b1;
      repeat (4) @(negedge clk);
      #1;
      total++;
      if (busy !== 1'b0 || bias_valid !== 1'b0 || dn_c.size() !== 0) begin
         bad++;
         $display("FAIL rflush_after got=%b%b/%0d want=00/0",
                  busy, bias_valid, dn_c.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_bias_block();
      test_zero();
      test_abort();
      test_reset_flush();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
